// File: rtl/spram_rr_arbiter_if.sv
// Bundle of the two client request/response channels and the single-port RAM
// port that spram_rr_arbiter sits between.
//   slave  : arbiter side (takes requests and RAM read data, drives acks,
//            responses and the RAM control/address/data registers)
//   master : environment side (clients plus the RAM itself)
// Per requester X in {0,1}: mX_req/we/addr/wdata in, mX_ack (combinational),
// mX_rvalid (registered), mX_rdata out.
// RAM: ram_enable, ram_read_en, ram_address, ram_data_in out; ram_data_out in.
interface spram_rr_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned ADDR  = $clog2(DEPTH)
);
    logic             m0_req;
    logic             m0_we;
    logic [ADDR-1:0]  m0_addr;
    logic [WIDTH-1:0] m0_wdata;
    logic             m0_ack;
    logic             m0_rvalid;
    logic [WIDTH-1:0] m0_rdata;

    logic             m1_req;
    logic             m1_we;
    logic [ADDR-1:0]  m1_addr;
    logic [WIDTH-1:0] m1_wdata;
    logic             m1_ack;
    logic             m1_rvalid;
    logic [WIDTH-1:0] m1_rdata;

    logic             ram_enable;
    logic             ram_read_en;
    logic [ADDR-1:0]  ram_address;
    logic [WIDTH-1:0] ram_data_in;
    logic [WIDTH-1:0] ram_data_out;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  ram_data_out,
        output m0_ack, m0_rvalid, m0_rdata,
        output m1_ack, m1_rvalid, m1_rdata,
        output ram_enable, ram_read_en, ram_address, ram_data_in
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output ram_data_out,
        input  m0_ack, m0_rvalid, m0_rdata,
        input  m1_ack, m1_rvalid, m1_rdata,
        input  ram_enable, ram_read_en, ram_address, ram_data_in
    );
endinterface

// File: rtl/spram_rr_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single-port RAM
// with registered read data. One access is issued per cycle; read data comes
// back to the owning requester two cycles after its ack, in grant order.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : spram_rr_arbiter_if.slave (client channels m0/m1 and the RAM port)
module spram_rr_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input logic               clk,
    input logic               rst,
    spram_rr_arbiter_if.slave bus
);
    localparam int unsigned ADDR = $clog2(DEPTH);

    // Arbitration result for the current cycle
    logic             gnt0_c;
    logic             gnt1_c;
    logic             gnt_any_c;
    logic             gnt_we_c;
    logic [ADDR-1:0]  gnt_addr_c;
    logic [WIDTH-1:0] gnt_wdata_c;

    // prio_q: 0 favours requester 0, 1 favours requester 1
    logic             prio_q,     prio_d;
    logic             ram_en_q,   ram_en_d;
    logic             ram_rd_q,   ram_rd_d;
    logic [ADDR-1:0]  ram_addr_q, ram_addr_d;
    logic [WIDTH-1:0] ram_din_q,  ram_din_d;
    // Stage-1 tag: access currently presented to the RAM
    logic             s1_rd0_q,   s1_rd0_d;
    logic             s1_rd1_q,   s1_rd1_d;
    // Stage-2 tag: RAM output holds data for this requester
    logic             rvalid0_q,  rvalid0_d;
    logic             rvalid1_q,  rvalid1_d;

    // Round-robin grant: a lone requester wins, a tie goes to prio_q
    always_comb begin
        gnt0_c      = bus.m0_req & (~bus.m1_req | ~prio_q);
        gnt1_c      = bus.m1_req & (~bus.m0_req |  prio_q);
        gnt_any_c   = gnt0_c | gnt1_c;
        gnt_we_c    = gnt1_c ? bus.m1_we    : bus.m0_we;
        gnt_addr_c  = gnt1_c ? bus.m1_addr  : bus.m0_addr;
        gnt_wdata_c = gnt1_c ? bus.m1_wdata : bus.m0_wdata;
    end

    // Next state for issue register, tag pipeline and priority pointer
    always_comb begin
        prio_d     = prio_q;
        ram_en_d   = 1'b0;
        ram_rd_d   = ram_rd_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        s1_rd0_d   = 1'b0;
        s1_rd1_d   = 1'b0;
        rvalid0_d  = s1_rd0_q;
        rvalid1_d  = s1_rd1_q;
        if (gnt_any_c) begin
            prio_d     = ~gnt1_c;
            ram_en_d   = 1'b1;
            ram_rd_d   = ~gnt_we_c;
            ram_addr_d = gnt_addr_c;
            ram_din_d  = gnt_wdata_c;
            s1_rd0_d   = gnt0_c & ~gnt_we_c;
            s1_rd1_d   = gnt1_c & ~gnt_we_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q     <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_rd_q   <= 1'b1;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            s1_rd0_q   <= 1'b0;
            s1_rd1_q   <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
        end else begin
            prio_q     <= prio_d;
            ram_en_q   <= ram_en_d;
            ram_rd_q   <= ram_rd_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            s1_rd0_q   <= s1_rd0_d;
            s1_rd1_q   <= s1_rd1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
        end
    end

    assign bus.m0_ack      = gnt0_c;
    assign bus.m1_ack      = gnt1_c;
    assign bus.m0_rvalid   = rvalid0_q;
    assign bus.m1_rvalid   = rvalid1_q;
    // RAM read data is broadcast; rvalid says who owns it
    assign bus.m0_rdata    = bus.ram_data_out;
    assign bus.m1_rdata    = bus.ram_data_out;
    assign bus.ram_enable  = ram_en_q;
    assign bus.ram_read_en = ram_rd_q;
    assign bus.ram_address = ram_addr_q;
    assign bus.ram_data_in = ram_din_q;
endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Bench for spram_rr_arbiter: behavioural RAM, directed scenarios followed by
// random traffic, all checked against a memory-array / response-queue model.
module tb_spram_rr_arbiter;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spram_rr_arbiter_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    spram_rr_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Single-port RAM: registered read, write when read_en low, gated by enable
    logic [WIDTH-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (bus.ram_enable) begin
            if (!bus.ram_read_en) ram_mem[bus.ram_address] <= bus.ram_data_in;
            else                  bus.ram_data_out <= ram_mem[bus.ram_address];
        end
    end

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [7:0]  data;
        int unsigned due;
    } rsp_t;
    rsp_t exp_q[$];

    // Reference model: memory contents in grant order, priority, issued access
    logic [7:0] ref_mem [DEPTH];
    bit         ref_prio;
    bit         ref_en;
    bit         ref_rd;
    logic [3:0] ref_addr;
    logic [7:0] ref_din;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endfunction

    function automatic void check_ram();
        chk("ram_enable",  32'(bus.ram_enable),  32'(ref_en));
        chk("ram_read_en", 32'(bus.ram_read_en), 32'(ref_rd));
        chk("ram_address", 32'(bus.ram_address), 32'(ref_addr));
        chk("ram_data_in", 32'(bus.ram_data_in), 32'(ref_din));
    endfunction

    // One clock cycle: drive requests, then check acks and RAM port, update model
    task automatic step(input bit r0, input bit w0, input logic [3:0] a0, input logic [7:0] d0,
                        input bit r1, input bit w1, input logic [3:0] a1, input logic [7:0] d1,
                        output bit g0, output bit g1);
        int   win;
        bit   we;
        logic [3:0] a;
        logic [7:0] d;
        rsp_t r;
        @(posedge clk);
        #1;
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
        @(negedge clk);
        if (r0 && r1)  win = ref_prio ? 1 : 0;
        else if (r0)   win = 0;
        else if (r1)   win = 1;
        else           win = -1;
        g0 = (win == 0);
        g1 = (win == 1);
        chk("m0_ack", 32'(bus.m0_ack), 32'(g0));
        chk("m1_ack", 32'(bus.m1_ack), 32'(g1));
        check_ram();
        if (win >= 0) begin
            we = (win == 1) ? w1 : w0;
            a  = (win == 1) ? a1 : a0;
            d  = (win == 1) ? d1 : d0;
            ref_en   = 1'b1;
            ref_rd   = !we;
            ref_addr = a;
            ref_din  = d;
            if (we) begin
                ref_mem[a] = d;
            end else begin
                r.id   = win;
                r.data = ref_mem[a];
                r.due  = cyc + 2;
                exp_q.push_back(r);
            end
            ref_prio = (win == 0);
        end else begin
            ref_en = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        bit g0, g1;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        exp_q.delete();
        ref_prio = 1'b0;
        ref_en   = 1'b0;
        ref_rd   = 1'b1;
        ref_addr = '0;
        ref_din  = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_ram();
            chk("reset_m0_rvalid", 32'(bus.m0_rvalid), 32'd0);
            chk("reset_m1_rvalid", 32'(bus.m1_rvalid), 32'd0);
            if (i < n - 1) @(posedge clk);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Response monitor: every rvalid must match the oldest outstanding read
    always @(negedge clk) begin
        rsp_t r;
        if (!rst) begin
            if (bus.m0_rvalid === 1'b1 && bus.m1_rvalid === 1'b1)
                chk("rvalid_both", 32'd1, 32'd0);
            if (bus.m0_rvalid === 1'b1 || bus.m1_rvalid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk("rsp_id",      32'(bus.m1_rvalid === 1'b1), 32'(r.id));
                    chk("rsp_latency", 32'(cyc), 32'(r.due));
                    chk("rsp_data", 32'(bus.m1_rvalid === 1'b1 ? bus.m1_rdata : bus.m0_rdata),
                        32'(r.data));
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                r = exp_q.pop_front();
                chk("rsp_missing", 32'd0, 32'd1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        bit g0, g1;
        bit p0, pw0, p1, pw1;
        logic [3:0] pa0, pa1;
        logic [7:0] pd0, pd1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;

        // Reset then idle
        do_reset(2);
        idle(3);

        // Single write then read, requester 0
        step(1, 1, 4'd3, 8'hA5, 0, 0, 0, 0, g0, g1);
        chk("t2_write_ack", 32'(g0), 32'd1);
        step(1, 0, 4'd3, 8'h00, 0, 0, 0, 0, g0, g1);
        chk("t2_read_ack", 32'(g0), 32'd1);
        chk("t2_read_data_model", 32'(ref_mem[3]), 32'hA5);
        idle(3);

        // Preload, then contention: acks must alternate starting with m0
        step(1, 1, 4'd1, 8'h11, 0, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 1, 1, 4'd2, 8'h22, g0, g1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 4'd1, 0, 1, 0, 4'd2, 0, g0, g1);
            chk("t3_alternate", 32'(g1), 32'(i % 2));
        end
        idle(3);

        // Fairness after a lone grant
        step(0, 0, 0, 0, 1, 0, 4'd2, 0, g0, g1);
        step(1, 0, 4'd1, 0, 1, 0, 4'd2, 0, g0, g1);
        chk("t4_m0_after_m1", 32'(g0), 32'd1);
        idle(1);
        step(1, 0, 4'd1, 0, 0, 0, 0, 0, g0, g1);
        step(1, 0, 4'd1, 0, 1, 0, 4'd2, 0, g0, g1);
        chk("t4_m1_after_m0", 32'(g1), 32'd1);
        idle(3);

        // Back-to-back write/read to address 15 from different requesters
        step(1, 1, 4'd15, 8'h5A, 0, 0, 0, 0, g0, g1);
        step(0, 0, 0, 0, 1, 0, 4'd15, 0, g0, g1);
        chk("t5_read_ack", 32'(g1), 32'd1);
        idle(4);

        // Reset one cycle after a read ack: response discarded, prio back to 0
        step(1, 0, 4'd3, 0, 0, 0, 0, 0, g0, g1);
        do_reset(1);
        idle(4);
        step(1, 0, 4'd1, 0, 1, 0, 4'd2, 0, g0, g1);
        chk("t6_m0_after_reset", 32'(g0), 32'd1);
        idle(3);

        // Random traffic; a request is held until acked, then replaced
        p0 = 0; p1 = 0;
        pw0 = 0; pw1 = 0; pa0 = 0; pa1 = 0; pd0 = 0; pd1 = 0;
        for (int i = 0; i < 500; i++) begin
            if (!p0) begin
                p0  = ($urandom_range(0, 3) != 0);
                pw0 = $urandom_range(0, 1) == 1;
                pa0 = 4'($urandom_range(0, 15));
                pd0 = 8'($urandom_range(0, 255));
            end
            if (!p1) begin
                p1  = ($urandom_range(0, 3) != 0);
                pw1 = $urandom_range(0, 1) == 1;
                pa1 = 4'($urandom_range(0, 15));
                pd1 = 8'($urandom_range(0, 255));
            end
            step(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, g0, g1);
            if (g0) p0 = 0;
            if (g1) p1 = 0;
        end
        idle(5);
        chk("responses_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spram_rr_arbiter.md
Name: spram_rr_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port RAM (WIDTH x DEPTH, registered read, write when read_en low, gated by enable).
- Sits between two client masters and the RAM. Issues at most one access per cycle and returns read data with a valid strobe to the owning requester.
- Sustains back-to-back accesses with no bubbles and never starves either requester.

Parameters:
- WIDTH, 8, data word width (matches RAM)
- DEPTH, 16, RAM word count
- ADDR, $clog2(DEPTH) = 4, address width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- m0_req  in  1  requester 0 access request; held with its qualifiers until m0_ack
- m0_we  in  1  requester 0: 1 = write, 0 = read
- m0_addr  in  ADDR  requester 0 address
- m0_wdata  in  WIDTH  requester 0 write data
- m0_ack  out  1  combinational; request accepted this cycle
- m0_rvalid  out  1  registered; m0_rdata valid this cycle
- m0_rdata  out  WIDTH  read data to requester 0
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rvalid, m1_rdata: same as the m0_* signals, for requester 1
- ram_enable  out  1  registered RAM enable
- ram_read_en  out  1  registered; 1 = read, 0 = write (equals ~we of the granted request)
- ram_address  out  ADDR  registered RAM address
- ram_data_in  out  WIDTH  registered RAM write data
- ram_data_out  in  WIDTH  RAM registered read data

Behaviour:
- Reset: asynchronous and active-high.
  - ram_enable=0, ram_read_en=1, ram_address=0, ram_data_in=0.
  - m0_rvalid=m1_rvalid=0.
  - Pipeline tags cleared; priority pointer prio=0 (requester 0 favoured).
- Arbitration (combinational, cycle N):
  - Only one requester asserting req: that requester is granted.
  - Both asserting req: the requester indicated by prio is granted.
  - mX_ack = grant to X. At most one ack per cycle; with no req, no ack.
- Priority update at edge ending N: when a grant occurs, prio <= ~granted_id. With no grant, prio holds.
- Issue stage (edge ending N):
  - Grant: ram_enable<=1, ram_read_en<=~we, ram_address<=addr, ram_data_in<=wdata.
  - Stage-1 tag <= {read, id}.
  - No grant: ram_enable<=0; other RAM outputs hold; tag invalid.
- RAM stage (edge ending N+1): RAM performs the access; stage-2 tag <= stage-1 tag.
- Response (cycle N+2):
  - If the stage-2 tag marks a read from X: mX_rvalid=1 for exactly one cycle; mX_rdata = ram_data_out.
  - Writes produce no rvalid.
  - Read latency from ack = 2 cycles.
- mX_rdata is driven from ram_data_out at all times. It is only meaningful while mX_rvalid=1.
- Throughput: one access per cycle. Accesses retire in grant order; responses are never reordered.
- Requester drops or changes req the cycle after ack. If req stays high after ack, it is a new request.
- Ordering: a write followed by a read to the same address in consecutive grants returns the new data. No forwarding logic is needed; the RAM serialises the two accesses on separate edges.
- Reset mid-operation: in-flight accesses are discarded, no rvalid is emitted afterwards, and prio returns to 0. A write already issued to the RAM before the reset edge may or may not complete.
- Out-of-range address (ADDR wide, DEPTH a power of 2): cannot occur; no checking.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then no req → all outputs stay at reset values and ram_enable=0 throughout.
2. Single write/read, requester 0:
   - Write addr 3 data 0xA5 (m0_ack same cycle); next cycle read addr 3.
   - Required: ram_enable high for 2 consecutive cycles, ram_read_en 0 then 1; m0_rvalid=1 exactly 2 cycles after the read ack with m0_rdata=0xA5; m1_rvalid stays 0.
3. Contention:
   - Both req reads every cycle for 4 cycles, m0 at addr 1 (pre-loaded 0x11), m1 at addr 2 (pre-loaded 0x22).
   - Required: acks alternate m0,m1,m0,m1; rvalids alternate m0,m1,m0,m1 at +2 cycles with data 0x11/0x22.
4. Fairness after a lone grant:
   - m1 alone is granted, then both req the next cycle → m0 is granted.
   - m0 alone is granted, then both req → m1 is granted.
5. Back-to-back write/read mix:
   - m0 writes 0x5A to addr 15; m1 reads addr 15 in the very next cycle.
   - Required: m1_rvalid with m1_rdata=0x5A; there are no idle ram_enable cycles between the two accesses.
6. Reset mid-read:
   - m0 read is acked; rst is asserted 1 cycle later.
   - Required: m0_rvalid never asserts, ram_enable=0 immediately, and the next contended request after reset is granted to m0.
